// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Used by both the receive and transmit stages.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: tick/serial line into the receiver, byte/done/error out.
// Latency: none (wires only); backpressure: none, the consumer must take each done pulse.
interface uart_rx_if #(
    parameter int NB_DATA = 8
);
    logic               i_tick;
    logic               i_rx;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done_tick;
    logic               o_frame_error;

    modport master (
        output i_tick, i_rx,
        input  o_data, o_rx_done_tick, o_frame_error
    );

    modport slave (
        input  i_tick, i_rx,
        output o_data, o_rx_done_tick, o_frame_error
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low reset to RST_VAL.
// Latency: 2 clocks d -> q; backpressure: none.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; byte, done pulse and framing-error flag out.
// Latency: done ~2 clocks + (MID_TICK+1 + 16*NB_DATA + SB_TICK) ticks after start edge; backpressure: none.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic      i_clk,
    input  logic      i_reset,
    uart_rx_if.slave  bus
);
    localparam int S_W = $clog2(max_int(OVERSAMPLE, SB_TICK));
    localparam int N_W = $clog2(NB_DATA);

    state_t             state, state_nxt;
    logic [S_W-1:0]     s_q;
    logic [N_W-1:0]     n_q;
    logic [NB_DATA-1:0] b_q;
    logic               rx_s;

    logic s_mid, s_bit_end, s_stop_end, n_last;
    logic s_clr, s_inc, n_clr, n_inc, b_shift, frame_end;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (i_clk),
        .rst_n (i_reset),
        .d     (bus.i_rx),
        .q     (rx_s)
    );

    assign s_mid      = (s_q == S_W'(MID_TICK));
    assign s_bit_end  = (s_q == S_W'(OVERSAMPLE - 1));
    assign s_stop_end = (s_q == S_W'(SB_TICK - 1));
    assign n_last     = (n_q == N_W'(NB_DATA - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!rx_s) state_nxt = ST_START;
            ST_START: if (bus.i_tick && s_mid) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (bus.i_tick && s_bit_end && n_last) state_nxt = ST_STOP;
            ST_STOP:  if (bus.i_tick && s_stop_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_clr     = 1'b0;
        s_inc     = 1'b0;
        n_clr     = 1'b0;
        n_inc     = 1'b0;
        b_shift   = 1'b0;
        frame_end = 1'b0;
        case (state)
            // Tick is deliberately ignored here; only the line edge matters.
            ST_IDLE: s_clr = ~rx_s;
            ST_START: if (bus.i_tick) begin
                if (s_mid) begin
                    s_clr = 1'b1;
                    n_clr = 1'b1;
                end else begin
                    s_inc = 1'b1;
                end
            end
            ST_DATA: if (bus.i_tick) begin
                if (s_bit_end) begin
                    s_clr   = 1'b1;
                    b_shift = 1'b1;
                    n_inc   = ~n_last;
                end else begin
                    s_inc = 1'b1;
                end
            end
            ST_STOP: if (bus.i_tick) begin
                if (s_stop_end) begin
                    s_clr     = 1'b1;
                    frame_end = 1'b1;
                end else begin
                    s_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            s_q                <= '0;
            n_q                <= '0;
            b_q                <= '0;
            bus.o_data         <= '0;
            bus.o_rx_done_tick <= 1'b0;
            bus.o_frame_error  <= 1'b0;
        end else begin
            bus.o_rx_done_tick <= frame_end;
            if (s_clr)      s_q <= '0;
            else if (s_inc) s_q <= s_q + S_W'(1);
            if (n_clr)      n_q <= '0;
            else if (n_inc) n_q <= n_q + N_W'(1);
            if (b_shift)    b_q <= {rx_s, b_q[NB_DATA-1:1]};
            // A bad stop bit still delivers the byte; the error flag qualifies it.
            if (frame_end) begin
                bus.o_data        <= b_q;
                bus.o_frame_error <= ~rx_s;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx: a queue of expected (byte, error) per sent frame
// is matched against every done pulse.
module tb_uart_rx;
    localparam int NB_DATA = 8;
    localparam int SB_TICK = 16;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tick_div = 4;
    int   tick_cnt = 0;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   done_cnt = 0;
    int   sent_cnt = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    int   last_gap = 0;
    logic prev_done = 1'b0;
    logic [7:0] model_data = 8'h00;
    logic       model_ferr = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    uart_rx_if #(.NB_DATA(NB_DATA)) bus();

    uart_rx #(.NB_DATA(NB_DATA), .SB_TICK(SB_TICK)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    // Baud tick: one cycle every tick_div clocks (tick_div = 1 gives a continuous tick).
    always @(negedge clk) begin
        if (tick_cnt >= tick_div - 1) begin
            tick_cnt   = 0;
            bus.i_tick = 1'b1;
        end else begin
            tick_cnt   = tick_cnt + 1;
            bus.i_tick = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n === 1'b1 && bus.o_rx_done_tick === 1'b1) begin
            done_cnt++;
            last_gap      = cyc - last_done_cyc;
            last_done_cyc = cyc;
            check_eq("done_width", 32'(prev_done), 32'h0);
            check_eq("expected_pending", 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_eq("rx_data", 32'(bus.o_data), 32'(mon_e.data));
                check_eq("rx_ferr", 32'(bus.o_frame_error), 32'(mon_e.ferr));
                model_data = mon_e.data;
                model_ferr = mon_e.ferr;
            end
        end
        prev_done = bus.o_rx_done_tick;
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (bus.i_tick) k++;
        end
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int nt);
        bus.i_rx = v;
        wait_ticks(nt);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic ferr);
        exp_t e;
        e.data = d;
        e.ferr = ferr;
        exp_q.push_back(e);
        sent_cnt++;
    endtask

    // Line-level transmitter. A bad stop bit is low over its sample point and
    // high for its last quarter, so the receiver does not re-arm on it.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        expect_frame(d, ~stop_ok);
        drive_bit(1'b0, 16);
        for (int i = 0; i < NB_DATA; i++) drive_bit(d[i], 16);
        if (stop_ok) begin
            drive_bit(1'b1, SB_TICK);
        end else begin
            drive_bit(1'b0, SB_TICK - 4);
            drive_bit(1'b1, 4);
        end
    endtask

    task automatic settle(input string tag, input int nt);
        drive_bit(1'b1, nt);
        check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
        check_eq({tag, "_count"}, 32'(done_cnt), 32'(sent_cnt));
    endtask

    initial begin
        #1_600_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       ok;
        bus.i_rx   = 1'b1;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_data", 32'(bus.o_data), 32'h0);
        check_eq("rst_done", 32'(bus.o_rx_done_tick), 32'h0);
        check_eq("rst_ferr", 32'(bus.o_frame_error), 32'h0);
        rst_n = 1'b1;
        drive_bit(1'b1, 20);

        send_frame(8'hE5, 1'b1);
        settle("single", 40);
        check_eq("single_hold", 32'(bus.o_data), 32'hE5);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        settle("b2b", 10);
        check_eq("b2b_spacing", 32'(last_gap), 32'(160 * tick_div));

        drive_bit(1'b0, 3);
        settle("glitch", 40);
        check_eq("glitch_data", 32'(bus.o_data), 32'(model_data));
        send_frame(8'h96, 1'b1);
        settle("post_glitch", 10);

        send_frame(8'h5A, 1'b0);
        settle("ferr", 20);
        check_eq("ferr_held", 32'(bus.o_frame_error), 32'h1);
        send_frame(8'hA5, 1'b1);
        settle("ferr_clear", 10);
        check_eq("ferr_cleared", 32'(bus.o_frame_error), 32'h0);

        // Reset in the middle of data bit 4 of a frame that must never complete.
        d = 8'hC3;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 16);
        drive_bit(d[4], 8);
        rst_n    = 1'b0;
        bus.i_rx = 1'b1;
        #1;
        check_eq("midrst_data", 32'(bus.o_data), 32'h0);
        check_eq("midrst_done", 32'(bus.o_rx_done_tick), 32'h0);
        check_eq("midrst_ferr", 32'(bus.o_frame_error), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        model_data = 8'h00;
        settle("midrst_quiet", 200);
        check_eq("midrst_quiet_data", 32'(bus.o_data), 32'h0);
        send_frame(8'h3C, 1'b1);
        settle("post_rst", 10);

        // Break: each 152-tick frame time yields (0x00, error); 460 ticks gives three.
        for (int i = 0; i < 3; i++) expect_frame(8'h00, 1'b1);
        drive_bit(1'b0, 460);
        settle("break", 200);
        check_eq("break_data", 32'(bus.o_data), 32'h0);
        check_eq("break_ferr", 32'(bus.o_frame_error), 32'(model_ferr));

        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1);
            if ($urandom_range(0, 1) == 1) drive_bit(1'b1, $urandom_range(1, 6));
        end
        settle("rand_good", 10);

        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom_range(0, 255));
            ok = 1'($urandom_range(0, 1));
            send_frame(d, ok);
            drive_bit(1'b1, $urandom_range(0, 4));
        end
        settle("rand_stop", 10);

        tick_div = 1;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1);
        end
        settle("cont_tick", 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive stage of the UART datapath.
- Deserialises the 8N1 line produced by the transmit stage using the shared 16x oversampling tick from the baud-rate generator.
- Presents each received byte with a one-cycle done pulse and a framing-error flag to the downstream command/ALU interface.
- Companion to the transmitter: same tick source, same NB_DATA/SB_TICK parameterisation.

Parameters:
- NB_DATA, 8, data bits per frame, LSB first.
- SB_TICK, 16, oversampling ticks spanning the stop bit(s); 16 = 1 stop bit, 32 = 2 stop bits.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- i_tick  input  1  one-cycle strobe at 16x baud from the baud-rate generator.
- i_rx  input  1  asynchronous serial line; idle high.
- o_data  output  NB_DATA  last received byte; held until the next frame completes.
- o_rx_done_tick  output  1  one-cycle pulse when a frame completes.
- o_frame_error  output  1  stop bit sampled low on the last frame; valid with o_rx_done_tick, held until the next completion.

Behaviour:
- Reset (i_reset = 0, async):
  - State IDLE; o_data = 0, o_rx_done_tick = 0, o_frame_error = 0.
  - Internal counters and shift register cleared.
  - Both synchroniser flops preset to 1 (idle line).
  - Reset mid-frame abandons the frame silently: no done pulse.
- Input synchroniser: i_rx passes through 2 flops -> rx_s. All decisions use rx_s. Latency from i_rx to rx_s is 2 clocks.
- Counters:
  - s (tick count) is $clog2(max(16,SB_TICK)) bits.
  - n (bit count) is $clog2(NB_DATA) bits.
  - b is an NB_DATA-bit shift register.
  - Counters advance only on cycles with i_tick = 1.
- FSM, one-hot or binary (implementer's choice):
  - IDLE: rx_s = 0 -> START with s = 0. i_tick is ignored in IDLE.
  - START, on tick:
    - If s == 7 (mid start bit): rx_s = 0 -> DATA with s = 0, n = 0. rx_s = 1 -> IDLE (glitch rejected, no output change).
    - Otherwise s++.
  - DATA, on tick:
    - If s == 15: s = 0, b = {rx_s, b[NB_DATA-1:1]}. Then n == NB_DATA-1 -> STOP, otherwise n++.
    - Otherwise s++.
  - STOP, on tick:
    - If s == SB_TICK-1: o_data <= b, o_frame_error <= ~rx_s, o_rx_done_tick <= 1 for exactly one cycle, then -> IDLE.
    - Otherwise s++.
- Sampling points:
  - Data bits are sampled at mid-bit (8 + 16k ticks after the start edge is detected).
  - The stop bit is sampled SB_TICK ticks after the last data sample.
- A frame with a framing error still pulses o_rx_done_tick and still updates o_data; the consumer qualifies the byte with o_frame_error.
- Back-to-back frames: the FSM is in IDLE on the clock after the done pulse, so a start edge already present is accepted with no lost frame.
- Line held low (break):
  - Produces a frame with o_data = 0 and o_frame_error = 1.
  - Because rx_s is still 0, the block re-enters START immediately and repeats the same result every frame time until the line returns high.
- No tick while idle has no effect; i_tick asserted continuously must not break the counting (every cycle counts as a tick).

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding localparams (IDLE/START/DATA/STOP).
  - The oversampling constant OVERSAMPLE = 16 and mid-bit constant MID_TICK = 7.
  - The transmitter reuses the same package.
- One sub-module: sync_2ff (2-flop synchroniser, async active-low reset to a parameterised value), instanced for i_rx.

Test Plan:
- Setup for all tests: 50 MHz clock, real baud-rate generator at 9600 baud.
  - Tick every 326 clocks.
  - Bit time 16 ticks, about 104.3 us.
- Send 8'hE5 (0b11100101) 8N1 -> one o_rx_done_tick, o_data = 8'hE5, o_frame_error = 0, no further pulses.
- Send 8'h00 then 8'hFF back-to-back with no idle gap -> two done pulses about 1.043 ms apart, data 8'h00 then 8'hFF, both with error 0.
- Drive a 3-tick low glitch on idle line -> no done pulse, FSM back in IDLE, o_data unchanged.
- Send 8'h5A with stop bit driven low -> done pulse, o_data = 8'h5A, o_frame_error = 1; a following good 8'hA5 frame clears the error to 0.
- Assert i_reset = 0 for 2 clocks during data bit 4 of a frame -> all outputs 0 immediately, no done pulse. A subsequent clean 8'h3C frame is received correctly.
- Loopback of the uart transmit stage into uart_rx, sending 8'h00 to 8'hFF -> 256 done pulses, o_data matches each sent byte, o_frame_error always 0.
